// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared definitions for the calculator operand-entry
//                controller: operation codes sent to the arithmetic core,
//                keypad key codes, FSM state encoding and small key-decode
//                helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operation select presented to the arithmetic core
    localparam logic [2:0] OP_MUL     = 3'b000;
    localparam logic [2:0] OP_DIV     = 3'b001;
    localparam logic [2:0] OP_SQRT    = 3'b010;
    localparam logic [2:0] OP_BIN2BCD = 3'b011;
    localparam logic [2:0] OP_BCD2BIN = 3'b100;

    // Keypad codes: 0x0-0x9 are digits, 0xA-0xE are operations, 0xF executes
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_MUL       = 4'hA;
    localparam logic [3:0] KEY_DIV       = 4'hB;
    localparam logic [3:0] KEY_SQRT      = 4'hC;
    localparam logic [3:0] KEY_BIN2BCD   = 4'hD;
    localparam logic [3:0] KEY_BCD2BIN   = 4'hE;
    localparam logic [3:0] KEY_EXECUTE   = 4'hF;

    // Entry limits
    localparam logic [19:0] BIN_ACC_MAX = 20'd65535;
    localparam logic [2:0]  MAX_DIGITS  = 3'd5;
    localparam logic [2:0]  BCD_DIGITS  = 3'd4;

    typedef enum logic [2:0] {
        ST_ENTRY = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= KEY_DIGIT_MAX);
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= KEY_MUL) && (key <= KEY_BCD2BIN);
    endfunction

    // Op keys are contiguous and in the same order as the op codes
    function automatic logic [2:0] key_to_op(input logic [3:0] key);
        logic [3:0] diff;
        diff = key - KEY_MUL;
        return diff[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : digit_accumulator
//  Description : Keeps the binary and BCD views of the operand being typed,
//                the digit count and the overflow check for the next digit.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst      : clock, synchronous active-high reset
//    clear         : synchronous clear of both accumulators and the count
//    acc_en        : append digit to both accumulators (already checked)
//    restart_en    : discard contents and load digit as the first digit
//    chain_en      : load chain_value into both accumulators, count = 5
//    digit         : digit value 0-9
//    chain_value   : previous result used for chained operations
//    bcd_mode      : operation is BCD2BIN (limits entry to 4 BCD digits)
//    bin_acc       : binary accumulator
//    bcd_acc       : BCD accumulator
//    digit_count   : digits entered, 0-5
//    overflow      : appending digit now would be rejected
// ============================================================================
module digit_accumulator
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        acc_en,
    input  logic        restart_en,
    input  logic        chain_en,
    input  logic [3:0]  digit,
    input  logic [15:0] chain_value,
    input  logic        bcd_mode,
    output logic [15:0] bin_acc,
    output logic [15:0] bcd_acc,
    output logic [2:0]  digit_count,
    output logic        overflow
);

    logic [15:0] r_bin_acc;
    logic [15:0] r_bcd_acc;
    logic [2:0]  r_digit_count;

    // 65535*10 + 9 = 655359 fits in 20 bits, so the check never wraps
    logic [19:0] w_bin_next;
    logic [2:0]  w_count_next;

    assign w_bin_next = ({4'd0, r_bin_acc} * 20'd10) + {16'd0, digit};

    // Leading zeros can push the count past five without overflowing the
    // value; the count saturates so it stays within its 0-5 range.
    assign w_count_next = (r_digit_count >= MAX_DIGITS) ? MAX_DIGITS
                                                        : r_digit_count + 3'd1;

    assign overflow = bcd_mode ? (r_digit_count >= BCD_DIGITS)
                               : (w_bin_next > BIN_ACC_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_bin_acc     <= 16'd0;
            r_bcd_acc     <= 16'd0;
            r_digit_count <= 3'd0;
        end else if (restart_en) begin
            r_bin_acc     <= {12'd0, digit};
            r_bcd_acc     <= {12'd0, digit};
            r_digit_count <= 3'd1;
        end else if (chain_en) begin
            r_bin_acc     <= chain_value;
            r_bcd_acc     <= chain_value;
            r_digit_count <= MAX_DIGITS;
        end else if (acc_en) begin
            r_bin_acc     <= w_bin_next[15:0];
            r_bcd_acc     <= {r_bcd_acc[11:0], digit};
            r_digit_count <= w_count_next;
        end
    end

    assign bin_acc     = r_bin_acc;
    assign bcd_acc     = r_bcd_acc;
    assign digit_count = r_digit_count;

endmodule
`default_nettype wire

// File: rtl/operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry_ctrl
//  Description : Keypad front end for an arithmetic core. Collects digits
//                into an operand, selects the operation, issues a one-cycle
//                start pulse, waits (with a stale-ready mask and a timeout)
//                for the core and latches its result.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    TIMEOUT_CYCLES : cycles in WAIT without core_ready before ERROR
//    READY_MASK     : cycles after start during which core_ready is ignored
//
//  Ports
//    clk, rst       : clock, synchronous active-high reset
//    key_valid      : one-cycle key strobe, key_code qualifies it
//    key_code       : 0-9 digit, A-E operation, F execute
//    key_clear      : one-cycle clear/abort strobe (beats key_valid)
//    core_result    : result from the core
//    core_ready     : done level from the core
//    operand_a      : operand to the core
//    operation      : op select to the core
//    start          : one-cycle start pulse
//    result_q       : latched result
//    result_valid   : result_q holds a valid result
//    busy           : high in ISSUE and WAIT
//    error          : sticky error flag
//    digit_count    : digits entered, 0-5
// ============================================================================
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned READY_MASK     = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_clear,
    input  logic [31:0] core_result,
    input  logic        core_ready,
    output logic [15:0] operand_a,
    output logic [2:0]  operation,
    output logic        start,
    output logic [31:0] result_q,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic [2:0]  digit_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    logic [2:0]         r_operation;
    logic               r_start;
    logic               r_busy;
    logic               r_error;
    logic               r_result_valid;
    logic [31:0]        r_result_q;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               w_key;
    logic               w_digit_key;
    logic               w_op_key;
    logic               w_acc_en;
    logic               w_restart_en;
    logic               w_chain_en;
    logic               w_bcd_mode;
    logic               w_overflow;
    logic               w_ready_seen;
    logic               w_timeout;
    logic [15:0]        w_bin_acc;
    logic [15:0]        w_bcd_acc;
    logic [2:0]         w_digit_count;

    // A clear in the same cycle drops the key entirely
    assign w_key       = key_valid & ~key_clear;
    assign w_digit_key = is_digit(key_code);
    assign w_op_key    = is_op(key_code);
    assign w_bcd_mode  = (r_operation == OP_BCD2BIN);

    assign w_acc_en     = w_key && w_digit_key && (r_state == ST_ENTRY) && !w_overflow;
    assign w_restart_en = w_key && w_digit_key && (r_state == ST_DONE);
    assign w_chain_en   = w_key && w_op_key    && (r_state == ST_DONE);

    // r_wait_cnt counts completed WAIT cycles; a done level still high from
    // the previous operation is ignored until the mask has elapsed.
    assign w_ready_seen = core_ready && (r_wait_cnt >= CNT_W'(READY_MASK));
    assign w_timeout    = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    digit_accumulator u_digit_accumulator (
        .clk         (clk),
        .rst         (rst),
        .clear       (key_clear),
        .acc_en      (w_acc_en),
        .restart_en  (w_restart_en),
        .chain_en    (w_chain_en),
        .digit       (key_code),
        .chain_value (r_result_q[15:0]),
        .bcd_mode    (w_bcd_mode),
        .bin_acc     (w_bin_acc),
        .bcd_acc     (w_bcd_acc),
        .digit_count (w_digit_count),
        .overflow    (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_ENTRY;
            r_operation    <= OP_MUL;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_q     <= 32'd0;
            r_wait_cnt     <= '0;
        end else if (key_clear) begin
            r_state        <= ST_ENTRY;
            r_operation    <= OP_MUL;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_result_valid <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (w_key) begin
                        if (w_digit_key) begin
                            if (w_overflow) begin
                                r_error <= 1'b1;
                            end
                        end else if (w_op_key) begin
                            r_operation <= key_to_op(key_code);
                        end else if ((w_digit_count != 3'd0) && !r_error) begin
                            // Remaining code is EXECUTE
                            r_state <= ST_ISSUE;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= '0;
                end

                ST_WAIT: begin
                    if (w_ready_seen) begin
                        r_result_q     <= core_result;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_DONE;
                    end else if (w_timeout) begin
                        r_error        <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (w_key) begin
                        if (w_digit_key) begin
                            r_result_valid <= 1'b0;
                            r_state        <= ST_ENTRY;
                        end else if (w_op_key) begin
                            // Chaining: the result becomes the next operand
                            r_operation <= key_to_op(key_code);
                            r_state     <= ST_ENTRY;
                        end
                    end
                end

                ST_ERROR: begin
                    // Only key_clear (handled above) leaves ERROR
                end

                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    // Accumulators are frozen outside ENTRY/DONE, so operand_a stays stable
    // from ISSUE until WAIT exits.
    assign operand_a    = w_bcd_mode ? w_bcd_acc : w_bin_acc;
    assign operation    = r_operation;
    assign start        = r_start;
    assign result_q     = r_result_q;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign error        = r_error;
    assign digit_count  = w_digit_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_entry_ctrl
//  Description : Self-checking bench for operand_entry_ctrl. Completed core
//                results are predicted into a queue when the core response
//                is driven and compared when the controller finishes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_entry_ctrl;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_clear;
    logic [31:0] core_result;
    logic        core_ready;
    logic [15:0] operand_a;
    logic [2:0]  operation;
    logic        start;
    logic [31:0] result_q;
    logic        result_valid;
    logic        busy;
    logic        error;
    logic [2:0]  digit_count;

    int          checks = 0;
    int          errors = 0;
    int          start_pulses = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    operand_entry_ctrl #(
        .TIMEOUT_CYCLES (4096),
        .READY_MASK     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_clear    (key_clear),
        .core_result  (core_result),
        .core_ready   (core_ready),
        .operand_a    (operand_a),
        .operation    (operation),
        .start        (start),
        .result_q     (result_q),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .digit_count  (digit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_operand_a"},    32'(operand_a),    32'd0);
        check({tag, "_operation"},    32'(operation),    32'd0);
        check({tag, "_start"},        32'(start),        32'd0);
        check({tag, "_result_q"},     result_q,          32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
        check({tag, "_digit_count"},  32'(digit_count),  32'd0);
    endtask

    // Scoreboard: a successful completion is busy falling with a valid result
    always @(negedge clk) begin
        if (start) start_pulses++;
        if (prev_busy && !busy && result_valid) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
            else
                check("sb_result_q", result_q, exp_q.pop_front());
        end
        prev_busy = busy;
    end

    initial begin
        int sp;
        int n;

        rst         = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        key_clear   = 1'b0;
        core_result = 32'd0;
        core_ready  = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Basic multiply: 123, core answers 246
        press(4'd1); press(4'd2); press(4'd3);
        check("t1_operand_a", 32'(operand_a), 32'd123);
        check("t1_digit_count", 32'(digit_count), 32'd3);
        press(KEY_MUL);
        check("t1_operation", 32'(operation), 32'(OP_MUL));
        sp = start_pulses;
        press(KEY_EXECUTE);
        check("t1_start_in_issue", 32'(start), 32'd1);
        check("t1_busy_in_issue", 32'(busy), 32'd1);
        tick();
        check("t1_start_in_wait", 32'(start), 32'd0);
        check("t1_operand_held", 32'(operand_a), 32'd123);
        tick();
        tick();
        core_ready  = 1'b1;
        core_result = 32'd246;
        exp_q.push_back(32'd246);
        tick();
        core_ready = 1'b0;
        check("t1_valid_latency", 32'(result_valid), 32'd1);
        check("t1_result_q", result_q, 32'd246);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_start_pulses", 32'(start_pulses - sp), 32'd1);

        // Chaining: op key in DONE reuses the result as operand
        press(KEY_DIV);
        check("t1c_operand_a", 32'(operand_a), 32'd246);
        check("t1c_digit_count", 32'(digit_count), 32'd5);
        check("t1c_operation", 32'(operation), 32'(OP_DIV));
        press(KEY_EXECUTE);
        tick(); tick(); tick();
        core_ready  = 1'b1;
        core_result = 32'd123;
        exp_q.push_back(32'd123);
        tick();
        core_ready = 1'b0;
        check("t1c_result_q", result_q, 32'd123);
        press(4'd4);
        check("t1d_digit_count", 32'(digit_count), 32'd1);
        check("t1d_operand_a", 32'(operand_a), 32'd4);
        check("t1d_result_valid", 32'(result_valid), 32'd0);

        // BCD entry limited to four digits
        do_clear();
        check("t2_clear_error", 32'(error), 32'd0);
        check("t2_clear_count", 32'(digit_count), 32'd0);
        check("t2_clear_op", 32'(operation), 32'(OP_MUL));
        press(KEY_BCD2BIN);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("t2_operand_bcd", 32'(operand_a), 32'h1234);
        check("t2_operation", 32'(operation), 32'(OP_BCD2BIN));
        press(4'd5);
        check("t2_reject_error", 32'(error), 32'd1);
        check("t2_reject_count", 32'(digit_count), 32'd4);
        check("t2_reject_operand", 32'(operand_a), 32'h1234);

        // Binary overflow at 65535
        do_clear();
        press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd5);
        check("t3_operand_max", 32'(operand_a), 32'd65535);
        check("t3_error_before", 32'(error), 32'd0);
        press(4'd9);
        check("t3_operand_kept", 32'(operand_a), 32'd65535);
        check("t3_overflow_error", 32'(error), 32'd1);
        check("t3_count_kept", 32'(digit_count), 32'd5);
        sp = start_pulses;
        press(KEY_EXECUTE);
        tick(); tick();
        check("t3_exec_ignored", 32'(start_pulses - sp), 32'd0);
        check("t3_not_busy", 32'(busy), 32'd0);

        // Stale ready is masked, then timeout into ERROR
        do_clear();
        core_ready  = 1'b1;
        core_result = 32'hBAD;
        press(4'd9);
        press(KEY_EXECUTE);
        tick(); tick(); tick();
        core_ready = 1'b0;
        n = 0;
        while (!error && n < 5000) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n + 3), 32'd4097);
        check("t4_error", 32'(error), 32'd1);
        check("t4_result_valid", 32'(result_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        press(4'd3);
        check("t4_error_ignores_digit", 32'(digit_count), 32'd1);
        press(KEY_EXECUTE);
        check("t4_error_ignores_exec", 32'(busy), 32'd0);

        // Abort mid-WAIT, late ready ignored
        do_clear();
        press(4'd2);
        press(KEY_EXECUTE);
        tick(); tick();
        check("t5_busy_wait", 32'(busy), 32'd1);
        do_clear();
        core_ready  = 1'b1;
        core_result = 32'd77;
        tick(); tick(); tick(); tick();
        core_ready = 1'b0;
        check("t5_result_valid", 32'(result_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_error", 32'(error), 32'd0);
        check("t5_count", 32'(digit_count), 32'd0);
        press(4'd7);
        check("t5_entry_operand", 32'(operand_a), 32'd7);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd5;
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        check("t5_clear_wins_count", 32'(digit_count), 32'd0);
        check("t5_clear_wins_operand", 32'(operand_a), 32'd0);

        // Reset mid-WAIT
        press(4'd8);
        press(KEY_EXECUTE);
        tick(); tick();
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("t6_rst");
        rst = 1'b0;
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, 4096, cycles in WAIT without core_ready before the error exit.
REQ-002 Parameter SHALL be: READY_MASK, 2, cycles after start during which core_ready is ignored.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0x0-0x9 digit; 0xA MUL, 0xB DIV, 0xC SQRT, 0xD BIN2BCD, 0xE BCD2BIN; 0xF EXECUTE
- key_clear  in  1  one-cycle clear/abort strobe
- core_result  in  32  result from the arithmetic core
- core_ready  in  1  done level from the arithmetic core
- operand_a  out  16  operand to the core
- operation  out  3  op select to the core: 000 MUL, 001 DIV, 010 SQRT, 011 BIN2BCD, 100 BCD2BIN
- start  out  1  one-cycle start pulse to the core
- result_q  out  32  latched result
- result_valid  out  1  result_q holds a valid result
- busy  out  1  high in ISSUE and WAIT
- error  out  1  sticky error flag
- digit_count  out  3  number of digits entered, 0-5

Function
REQ-004 The FSM SHALL have states ENTRY, ISSUE, WAIT, DONE and ERROR.
REQ-005 Two accumulators SHALL run in parallel in ENTRY:
- bin_acc = bin_acc*10 + digit
- bcd_acc = {bcd_acc[11:0], digit}
REQ-006 operand_a SHALL be driven from bcd_acc when operation=100, and from bin_acc otherwise.
REQ-007 A digit key in ENTRY SHALL be rejected, with error=1 and the state unchanged, in either case:
- the new bin_acc would exceed 65535 while operation!=100;
- digit_count=4 while operation=100.
Accumulators and count SHALL be left unchanged.
REQ-008 An op key in ENTRY SHALL set operation and leave the accumulators and digit_count unchanged.
REQ-009 EXECUTE in ENTRY with digit_count>=1 and error=0 SHALL move to ISSUE; with digit_count=0 or error=1 it SHALL be ignored.
REQ-010 ISSUE SHALL last exactly one cycle with start=1, then move to WAIT; start SHALL be 0 in every other state.
REQ-011 operand_a and operation SHALL be held stable from ISSUE until WAIT exits.
REQ-012 WAIT SHALL ignore core_ready for the first READY_MASK cycles after start, so a stale done level is discarded.
REQ-013 When core_ready=1 after the mask:
- result_q SHALL take core_result and result_valid SHALL be 1 on the next edge;
- the state SHALL move to DONE.
Latency: result_valid rises one cycle after the first unmasked core_ready sample.
REQ-014 If TIMEOUT_CYCLES elapse in WAIT with no unmasked core_ready, the FSM SHALL move to ERROR with error=1 and result_valid=0.
REQ-015 key_valid in ISSUE or WAIT SHALL be ignored.
REQ-016 In DONE:
- a digit key SHALL clear the accumulators, load that digit (digit_count=1), set result_valid=0 and go to ENTRY;
- an op key SHALL load bin_acc=result_q[15:0], bcd_acc=result_q[15:0], digit_count=5, set operation, and go to ENTRY (chaining);
- EXECUTE SHALL be ignored.
REQ-017 In ERROR, all keys except key_clear SHALL be ignored.
REQ-018 key_clear in any state SHALL, on the next edge:
- go to ENTRY;
- clear both accumulators and digit_count;
- set operation=000, result_valid=0, error=0.
In WAIT this aborts the operation, and a later core_ready SHALL be ignored.
REQ-019 If key_clear and key_valid are asserted in the same cycle, clear SHALL win and the key SHALL be dropped.
REQ-020 busy SHALL be 1 exactly in ISSUE and WAIT.

Reset
REQ-021 rst=1 at a clock edge SHALL set state=ENTRY and clear all internal counters and accumulators.
REQ-022 The same rst edge SHALL set every output to zero: operand_a, operation=000, start, result_q, result_valid, busy, error, digit_count.
REQ-023 rst SHALL take priority over every other input, including mid-WAIT.

Structure
REQ-024 Package calc_pkg SHALL hold the operation codes, the key codes and the FSM state encoding.
REQ-025 Sub-module digit_accumulator SHALL hold bin_acc, bcd_acc, digit_count and the overflow check.
The FSM, mask/timeout counter and result register SHALL remain in the top level.

Verification
REQ-026 Keys 1,2,3, MUL, EXECUTE; core_ready after 3 cycles with core_result=246 -> operand_a=123 and start high exactly one cycle; result_q=246 and result_valid=1.
REQ-027 Keys BCD2BIN, 1,2,3,4 -> operand_a=0x1234; a fifth digit -> rejected, error=1, digit_count=4.
REQ-028 Keys 6,5,5,3,5, then digit 9 -> bin_acc stays 65535 and error=1; a following EXECUTE is ignored (start stays 0).
REQ-029 core_ready held high from the previous operation, then EXECUTE -> ready masked for 2 cycles; with no fresh ready for 4096 cycles -> ERROR, error=1.
REQ-030 key_clear mid-WAIT followed by a late core_ready -> state=ENTRY, result_valid=0.
REQ-031 rst mid-WAIT -> every output is 0 on the next edge.
